shift_rx_deser: RTL

//   Serial-to-parallel receive end for the 4-bit shift-register serial link.
//   - Hunts for a start bit (0) and shifts in WIDTH data bits.
//   - Checks the stop bit (1) and presents the word on A_par with a valid/ack handshake.
//   - The transmitting side supplies the bit-rate strobe (bit_en); this block only samples.

---
 rtl/shift_rx_deser_if.sv | 27 ++
 rtl/shift_rx_deser.sv | 135 +++++++++++++
 2 files changed

// File: rtl/shift_rx_deser_if.sv
// -----------------------------------------------------------------------------
// shift_rx_deser_if
//   Parallel-side bundle of the serial receive end: the received word, its
//   valid/ack handshake, and the status outputs (busy, frame_err, overrun).
//   master : receiver side (drives word and status, samples ack)
//   slave  : consumer side (samples word and status, drives ack)
// -----------------------------------------------------------------------------
interface shift_rx_deser_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] A_par;
  logic             valid;
  logic             ack;
  logic             busy;
  logic             frame_err;
  logic             overrun;

  modport master (
    output A_par, valid, busy, frame_err, overrun,
    input  ack
  );

  modport slave (
    input  A_par, valid, busy, frame_err, overrun,
    output ack
  );
endinterface

// File: rtl/shift_rx_deser.sv
// -----------------------------------------------------------------------------
// shift_rx_deser
//   Serial-to-parallel receive end of the shift-register serial link. Hunts for
//   a start bit (0), shifts in WIDTH data bits, checks the stop bit (1) and
//   presents the word with a valid/ack handshake. The transmitter supplies the
//   bit-rate strobe; this block only samples ser_in when bit_en=1.
// Ports
//   CLK     in  rising-edge clock
//   Clear   in  synchronous active-low reset
//   ser_in  in  serial data line, idle high
//   bit_en  in  one-CLK sample strobe
//   par     master modport: A_par, valid, busy, frame_err, overrun out; ack in
// Parameters
//   WIDTH     data bits per frame (>=2)
//   MSB_FIRST 1: first data bit lands in A_par[WIDTH-1]; 0: in A_par[0]
// -----------------------------------------------------------------------------
module shift_rx_deser #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                CLK,
  input  logic                Clear,
  input  logic                ser_in,
  input  logic                bit_en,
  shift_rx_deser_if.master    par
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sh_reg, sh_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] par_reg, par_next;
  logic             valid_reg, valid_next;
  logic             busy_reg;
  logic             ferr_reg, ferr_next;
  logic             ovr_reg, ovr_next;
  logic [WIDTH-1:0] sh_shifted;

  // Bit order is fixed at elaboration time.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign sh_shifted = {sh_reg[WIDTH-2:0], ser_in};
    end else begin : g_lsb_first
      assign sh_shifted = {ser_in, sh_reg[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    sh_next    = sh_reg;
    cnt_next   = cnt_reg;
    par_next   = par_reg;
    valid_next = valid_reg;
    ferr_next  = 1'b0;
    ovr_next   = 1'b0;

    // Consumer ack retires the word; a good frame completing on the same
    // edge overrides this below and keeps valid high with the new word.
    if (valid_reg && par.ack) begin
      valid_next = 1'b0;
    end

    if (bit_en) begin
      case (state_reg)
        IDLE: begin
          if (!ser_in) begin
            state_next = DATA;
            cnt_next   = '0;
          end
        end
        DATA: begin
          sh_next  = sh_shifted;
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == LAST_BIT) begin
            state_next = STOP;
          end
        end
        STOP: begin
          // No re-hunt here: a 0 stop bit is an error, not a new start bit.
          state_next = IDLE;
          if (ser_in) begin
            if (!valid_reg || par.ack) begin
              par_next   = sh_reg;
              valid_next = 1'b1;
            end else begin
              ovr_next = 1'b1;
            end
          end else begin
            ferr_next = 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!Clear) begin
      state_reg <= IDLE;
      sh_reg    <= '0;
      cnt_reg   <= '0;
      par_reg   <= '0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      ferr_reg  <= 1'b0;
      ovr_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      sh_reg    <= sh_next;
      cnt_reg   <= cnt_next;
      par_reg   <= par_next;
      valid_reg <= valid_next;
      busy_reg  <= (state_next != IDLE);
      ferr_reg  <= ferr_next;
      ovr_reg   <= ovr_next;
    end
  end

  assign par.A_par     = par_reg;
  assign par.valid     = valid_reg;
  assign par.busy      = busy_reg;
  assign par.frame_err = ferr_reg;
  assign par.overrun   = ovr_reg;

endmodule
